store_buffer: RTL

In-order store buffer between the MEM-stage pipeline register and the data memory port. Stores are queued with precomputed byte enables. Each queued store drains to memory on a later cycle in which no load is using the single memory port. Loads go straight through to memory unless they touch a word with a pending store, in which case they stall until that store has drained.

---
 rtl/store_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and the data memory port.
// Stores queue with byte enables and drain on cycles the port is idle.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int ALEN  = 32,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ALEN-1:0]          req_addr,
    input  logic [XLEN-1:0]          req_wdata,
    output logic                     req_ready,
    input  logic                     fence,
    output logic                     mem_write,
    output logic [3:0]               mem_be,
    output logic [2:0]               mem_funct3,
    output logic [ALEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misaligned
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ALEN-1:0]  e_addr  [DEPTH];
    logic [XLEN-1:0]  e_wdata [DEPTH];
    logic [3:0]       e_be    [DEPTH];
    logic [2:0]       e_f3    [DEPTH];
    logic [DEPTH-1:0] e_valid;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          mis_q;

    logic [1:0] off;
    logic [3:0] be_req;
    logic       mis_req;
    logic       conflict;
    logic       busy;
    logic       full;
    logic       fence_block;
    logic       is_load;
    logic       is_store;
    logic       mis_drop;
    logic       ld_issue;
    logic       st_acc;
    logic       drain;

    assign off = req_addr[1:0];

    // Byte-enable and alignment decode from access size and offset
    always_comb begin
        be_req  = 4'b0000;
        mis_req = 1'b0;
        unique case (req_funct3[1:0])
            2'b00: be_req = 4'b0001 << off;
            2'b01: begin
                be_req  = 4'b0011 << off;
                mis_req = (off == 2'd3);
            end
            default: begin
                be_req  = 4'b1111;
                mis_req = (off != 2'd0);
            end
        endcase
    end

    // A load conflicts with any pending store to the same word
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && e_addr[i][ALEN-1:2] == req_addr[ALEN-1:2]) begin
                conflict = 1'b1;
            end
        end
    end

    assign busy        = (cnt != '0);
    assign full        = (cnt == CW'(DEPTH));
    assign fence_block = fence & busy;
    assign is_load     = req_valid & ~req_write & ~mis_req;
    assign is_store    = req_valid & req_write & ~mis_req;

    assign mis_drop = req_valid & mis_req & ~fence_block & ~rst;
    assign ld_issue = is_load & ~fence_block & ~conflict & ~rst;
    assign st_acc   = is_store & ~fence_block & ~full & ~rst;
    assign drain    = ~ld_issue & busy;

    assign req_ready  = mis_drop | ld_issue | st_acc;
    assign empty      = ~busy;
    assign count      = cnt;
    assign misaligned = mis_q;

    // Memory port mux: issued load wins, else head-of-queue drain, else idle
    always_comb begin
        mem_write  = 1'b0;
        mem_be     = 4'b0000;
        mem_funct3 = 3'b000;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (ld_issue) begin
            mem_addr   = req_addr;
            mem_funct3 = req_funct3;
        end else if (drain) begin
            mem_write  = 1'b1;
            mem_be     = e_be[head];
            mem_funct3 = e_f3[head];
            mem_addr   = e_addr[head];
            mem_wdata  = e_wdata[head];
        end
    end

    // Pointers, occupancy, entry valid bits and the misaligned pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            mis_q   <= 1'b0;
            e_valid <= '0;
        end else begin
            mis_q <= mis_drop;
            if (drain) begin
                head          <= head + 1'b1;
                e_valid[head] <= 1'b0;
            end
            if (st_acc) begin
                tail          <= tail + 1'b1;
                e_valid[tail] <= 1'b1;
            end
            unique case ({st_acc, drain})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload; qualified by e_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (st_acc) begin
            e_addr[tail]  <= req_addr;
            e_wdata[tail] <= req_wdata;
            e_be[tail]    <= be_req;
            e_f3[tail]    <= req_funct3;
        end
    end

endmodule
